call_stack: RTL

- Parametrised hardware return-address stack for the DRFA CPU.
- Sits beside control_unit. CALL pushes the return PC; RET pops it back into the PC load path.
- Exports a 4-bit flag word that control_unit consumes as stack_flags.
- Generalises the fixed stack with configurable width and depth, an occupancy count, simultaneous push/pop (replace-top), and overflow/underflow reporting.

---
 rtl/drfa_pkg.sv | 30 +++
 rtl/call_stack_mem.sv | 48 ++++
 rtl/call_stack.sv | 109 ++++++++++
 3 files changed

// File: rtl/drfa_pkg.sv
// Shared DRFA CPU definitions: PC/stack defaults and the stack_flags bit layout
// that call_stack produces and control_unit consumes.
package drfa_pkg;

    localparam int PC_WIDTH    = 9;
    localparam int STACK_DEPTH = 8;

    localparam int STK_EMPTY     = 0;
    localparam int STK_FULL      = 1;
    localparam int STK_UNDERFLOW = 2;
    localparam int STK_OVERFLOW  = 3;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } stack_state_e;

    // The stack has no explicit FSM; its state is derived from the occupancy count.
    function automatic stack_state_e stack_state(input int unsigned count,
                                                 input int unsigned depth);
        if (count == 0)
            return ST_EMPTY;
        else if (count >= depth)
            return ST_FULL;
        else
            return ST_PARTIAL;
    endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x DATA_WIDTH registers, one write port and one
// asynchronous read port. Contents are cleared only by rst.
module call_stack_mem #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] entries;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] entry_d;
        logic [DATA_WIDTH-1:0] entry_q;

        always_comb begin
            entry_d = entry_q;
            if (wr_en && (wr_addr == ADDR_WIDTH'(gi)))
                entry_d = wr_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                entry_q <= '0;
            else
                entry_q <= entry_d;
        end

        assign entries[gi] = entry_q;
    end

    // Compare-based read mux so non-power-of-two depths need no special casing.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i))
                rd_data = entries[i];
        end
    end

endmodule

// File: rtl/call_stack.sv
// Return-address stack for the DRFA CPU: push/pop/replace-top with saturating
// count and overflow/underflow flags. CALL_STACK_STICKY_ERR_EN makes the error flags sticky.
module call_stack
    import drfa_pkg::*;
#(
    parameter int DATA_WIDTH = PC_WIDTH,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_en,
    input  logic                  pop_en,
`ifdef CALL_STACK_STICKY_ERR_EN
    input  logic                  err_clr,
`endif
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic [3:0]            out_flags
);

    stack_state_e          state;
    logic                  empty;
    logic                  full;
    logic [CNT_WIDTH-1:0]  count_d, count_q;
    logic                  ovf_d, ovf_q;
    logic                  unf_d, unf_q;
    logic                  ovf_evt, unf_evt;
    logic                  wr_en;
    logic [CNT_WIDTH-1:0]  wr_addr;
    logic [CNT_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    call_stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (CNT_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state   = stack_state(32'(count_q), 32'(DEPTH));
        empty   = (state == ST_EMPTY);
        full    = (state == ST_FULL);
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = count_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        rd_addr = count_q - CNT_WIDTH'(1);

        if (push_en && pop_en && !empty) begin
            // Replace-top: legal even when full, so no overflow is raised.
            wr_en   = 1'b1;
            wr_addr = count_q - CNT_WIDTH'(1);
        end else if (push_en) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (pop_en) begin
            if (empty)
                unf_evt = 1'b1;
            else
                count_d = count_q - CNT_WIDTH'(1);
        end

`ifdef CALL_STACK_STICKY_ERR_EN
        ovf_d = ovf_evt | (ovf_q & ~err_clr);
        unf_d = unf_evt | (unf_q & ~err_clr);
`else
        ovf_d = ovf_evt;
        unf_d = unf_evt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        out_data                 = empty ? '0 : rd_data;
        out_count                = count_q;
        out_flags                = '0;
        out_flags[STK_EMPTY]     = empty;
        out_flags[STK_FULL]      = full;
        out_flags[STK_UNDERFLOW] = unf_q;
        out_flags[STK_OVERFLOW]  = ovf_q;
    end

endmodule
